id_scoreboard: RTL and testbench

Parametrised register scoreboard for the ID stage. It generalises the fixed two-stage EXE/MEM load-dependence check to producers of any latency up to `2**LAT_W-1`, and adds multi-cycle HI/LO tracking for iterative mult/div. It sits beside the decode logic: it records each issued writer and counts down its remaining latency. It raises `stallreq_id` while a source of the instruction in ID is not yet bypassable.

---
 rtl/id_scoreboard.sv | 109 ++++++++++
 tb/tb_id_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
// ID-stage register scoreboard: per-register latency countdown plus a HI/LO
// countdown. A stall is requested while any source of the instruction in ID
// still has a nonzero count.
module id_scoreboard #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned LAT_W   = 3
) (
  input  logic               cpu_clk_50M,
  input  logic               cpu_rst_n,
  input  logic               issue,
  input  logic               issue_wreg,
  input  logic [AW-1:0]      issue_wa,
  input  logic [LAT_W-1:0]   issue_lat,
  input  logic               issue_whilo,
  input  logic [LAT_W-1:0]   issue_hilo_lat,
  input  logic               rreg1,
  input  logic               rreg2,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  input  logic               rhilo,
  input  logic               stall_ext,
  input  logic               flush,
  output logic               stallreq_id,
  output logic [REG_NUM-1:0] reg_busy,
  output logic               hilo_busy
);

  // Entry 0 exists only to keep indexing simple; it is held at zero.
  logic [LAT_W-1:0] cnt_q [REG_NUM];
  logic [LAT_W-1:0] cnt_d [REG_NUM];
  logic [LAT_W-1:0] hcnt_q;
  logic [LAT_W-1:0] hcnt_d;
  logic             dep1;
  logic             dep2;
  logic             deph;
  logic             acc;

  // Busy flags decoded straight from the registered counters.
  always_comb begin
    reg_busy = '0;
    for (int unsigned i = 1; i < REG_NUM; i++) begin
      reg_busy[i] = (cnt_q[i] != '0);
    end
  end

  assign hilo_busy = (hcnt_q != '0);

  // Source hazard lookup; addresses 0 and >= REG_NUM never match a busy entry.
  always_comb begin
    dep1 = 1'b0;
    dep2 = 1'b0;
    for (int unsigned i = 1; i < REG_NUM; i++) begin
      if (ra1 == AW'(i)) dep1 = reg_busy[i];
      if (ra2 == AW'(i)) dep2 = reg_busy[i];
    end
    dep1 = dep1 & rreg1;
    dep2 = dep2 & rreg2;
    deph = rhilo & hilo_busy;
  end

  assign stallreq_id = dep1 | dep2 | deph;
  assign acc         = issue & ~stallreq_id & ~stall_ext & ~flush;

  // Counter next state: flush, freeze, load on issue (WAW overwrite), count down.
  always_comb begin
    for (int unsigned i = 0; i < REG_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (flush) begin
        cnt_d[i] = '0;
      end else if (stall_ext) begin
        cnt_d[i] = cnt_q[i];
      end else if (acc && issue_wreg && (issue_wa == AW'(i))) begin
        cnt_d[i] = issue_lat;
      end else if (cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
    end

    hcnt_d = hcnt_q;
    if (flush) begin
      hcnt_d = '0;
    end else if (stall_ext) begin
      hcnt_d = hcnt_q;
    end else if (acc && issue_whilo) begin
      hcnt_d = issue_hilo_lat;
    end else if (hcnt_q != '0) begin
      hcnt_d = hcnt_q - LAT_W'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        cnt_q[i] <= '0;
      end
      hcnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < REG_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      hcnt_q <= hcnt_d;
    end
  end

endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: directed scenarios plus random traffic
// against a "ready time" reference model.
module tb_id_scoreboard;

  localparam int REG_NUM = 32;
  localparam int AW      = 5;
  localparam int LAT_W   = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               issue, issue_wreg, issue_whilo;
  logic [AW-1:0]      issue_wa;
  logic [LAT_W-1:0]   issue_lat, issue_hilo_lat;
  logic               rreg1, rreg2, rhilo, stall_ext, flush;
  logic [AW-1:0]      ra1, ra2;
  logic               stallreq_id, hilo_busy;
  logic [REG_NUM-1:0] reg_busy;

  always #5 clk = ~clk;

  id_scoreboard #(
    .REG_NUM(REG_NUM),
    .AW     (AW),
    .LAT_W  (LAT_W)
  ) u_dut (
    .cpu_clk_50M   (clk),
    .cpu_rst_n     (rst_n),
    .issue         (issue),
    .issue_wreg    (issue_wreg),
    .issue_wa      (issue_wa),
    .issue_lat     (issue_lat),
    .issue_whilo   (issue_whilo),
    .issue_hilo_lat(issue_hilo_lat),
    .rreg1         (rreg1),
    .rreg2         (rreg2),
    .ra1           (ra1),
    .ra2           (ra2),
    .rhilo         (rhilo),
    .stall_ext     (stall_ext),
    .flush         (flush),
    .stallreq_id   (stallreq_id),
    .reg_busy      (reg_busy),
    .hilo_busy     (hilo_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each register has the tick value at which it becomes bypassable;
  // tick advances once per non-frozen edge.
  int tick = 0;
  int ready [REG_NUM];
  int hready = 0;
  bit m_stall_pre;
  logic obs_stall;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int r);
    return (r != 0) && (r < REG_NUM) && (ready[r] > tick);
  endfunction

  function automatic bit m_stall();
    return (rreg1 && m_busy(int'(ra1))) || (rreg2 && m_busy(int'(ra2))) ||
           (rhilo && (hready > tick));
  endfunction

  task automatic m_clear();
    for (int i = 0; i < REG_NUM; i++) ready[i] = tick;
    hready = tick;
  endtask

  task automatic m_update(input bit stall_pre);
    if (!rst_n) begin
      m_clear();
    end else if (flush) begin
      m_clear();
    end else if (!stall_ext) begin
      tick++;
      if (issue && !stall_pre) begin
        if (issue_wreg && issue_wa != 0) ready[issue_wa] = tick + int'(issue_lat);
        if (issue_whilo) hready = tick + int'(issue_hilo_lat);
      end
    end
  endtask

  // Compare outputs with the model on current inputs, away from the edge.
  task automatic settle();
    logic [REG_NUM-1:0] exp_busy;
    #1;
    exp_busy = '0;
    for (int i = 0; i < REG_NUM; i++) exp_busy[i] = m_busy(i);
    m_stall_pre = m_stall();
    obs_stall   = stallreq_id;
    check_eq("model_stall", {63'd0, stallreq_id}, {63'd0, m_stall_pre});
    check_eq("model_reg_busy", {32'd0, reg_busy}, {32'd0, exp_busy});
    check_eq("model_hilo_busy", {63'd0, hilo_busy}, {63'd0, (hready > tick)});
  endtask

  task automatic edge_step();
    @(posedge clk);
    m_update(m_stall_pre);
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    edge_step();
  endtask

  task automatic idle();
    issue = 0; issue_wreg = 0; issue_wa = '0; issue_lat = '0;
    issue_whilo = 0; issue_hilo_lat = '0;
    rreg1 = 0; rreg2 = 0; ra1 = '0; ra2 = '0; rhilo = 0;
    stall_ext = 0; flush = 0;
  endtask

  task automatic do_issue(input int wa, input int lat, input bit wh, input int hlat);
    idle();
    issue = 1; issue_wreg = (wa >= 0); issue_wa = AW'(wa < 0 ? 0 : wa);
    issue_lat = LAT_W'(lat); issue_whilo = wh; issue_hilo_lat = LAT_W'(hlat);
    cycle();
  endtask

  // Counts stall cycles of the current reader (bounded); stall_ext raised in a window.
  task automatic count_stall(input int fz_start, input int fz_len, output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      stall_ext = (k >= fz_start) && (k < fz_start + fz_len);
      settle();
      if (!obs_stall) break;
      n++;
      edge_step();
    end
    stall_ext = 0;
  endtask

  int n;

  initial begin
    idle();
    rst_n = 0;
    m_clear();

    // Reset held with an issue pending: nothing recorded.
    issue = 1; issue_wreg = 1; issue_wa = 5; issue_lat = 3;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("rst_busy", {32'd0, reg_busy}, 64'd0);
      check_eq("rst_stall", {63'd0, stallreq_id}, 64'd0);
      edge_step();
    end
    rst_n = 1;
    idle(); rreg1 = 1; ra1 = 5;
    settle();
    check_eq("rst_r5_stall", {63'd0, stallreq_id}, 64'd0);
    edge_step();

    // Load-use, latency 2: stall, stall, go.
    do_issue(8, 2, 0, 0);
    idle(); rreg1 = 1; ra1 = 8;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("lu_stall", {63'd0, stallreq_id}, (k < 2) ? 64'd1 : 64'd0);
      check_eq("lu_busy8", {63'd0, reg_busy[8]}, (k < 2) ? 64'd1 : 64'd0);
      if (k < 2) edge_step();
    end
    edge_step();

    // Register 0 is never tracked.
    do_issue(0, 3, 0, 0);
    idle(); rreg1 = 1; ra1 = 0;
    settle();
    check_eq("r0_busy", {32'd0, reg_busy}, 64'd0);
    check_eq("r0_stall", {63'd0, stallreq_id}, 64'd0);
    edge_step();

    // Port 2: disabled read ignores the hazard, enabled read stalls one cycle.
    do_issue(9, 1, 0, 0);
    idle(); ra2 = 9; rreg2 = 0;
    settle();
    check_eq("p2_off_stall", {63'd0, stallreq_id}, 64'd0);
    rreg2 = 1;
    settle();
    check_eq("p2_on_stall", {63'd0, stallreq_id}, 64'd1);
    edge_step();
    settle();
    check_eq("p2_on_done", {63'd0, stallreq_id}, 64'd0);
    edge_step();

    // WAW overwrite: latest latency wins.
    do_issue(4, 1, 0, 0);
    do_issue(4, 3, 0, 0);
    idle(); rreg1 = 1; ra1 = 4;
    count_stall(100, 0, n);
    check_eq("waw_stall_len", 64'(n), 64'd3);
    edge_step();

    // Same with two frozen cycles mid-count: 3 + 2.
    do_issue(4, 1, 0, 0);
    do_issue(4, 3, 0, 0);
    idle(); rreg1 = 1; ra1 = 4;
    count_stall(1, 2, n);
    check_eq("frz_stall_len", 64'(n), 64'd5);
    edge_step();

    // HI/LO latency 7; an unrelated read in the first cycle does not stall.
    do_issue(-1, 0, 1, 7);
    idle(); rreg1 = 1; ra1 = 3;
    settle();
    check_eq("hl_unrel_stall", {63'd0, stallreq_id}, 64'd0);
    check_eq("hl_busy", {63'd0, hilo_busy}, 64'd1);
    edge_step();
    idle(); rhilo = 1;
    count_stall(100, 0, n);
    check_eq("hl_stall_len", 64'(n), 64'd6);  // one of the 7 cycles already elapsed
    edge_step();

    // Flush with r2=3, r6=2, hcnt=5 pending.
    do_issue(2, 4, 1, 6);
    do_issue(6, 2, 0, 0);
    idle(); flush = 1;
    cycle();
    idle(); rreg1 = 1; ra1 = 2; rreg2 = 1; ra2 = 6; rhilo = 1;
    settle();
    check_eq("fl_busy", {32'd0, reg_busy}, 64'd0);
    check_eq("fl_hilo", {63'd0, hilo_busy}, 64'd0);
    check_eq("fl_stall", {63'd0, stallreq_id}, 64'd0);
    edge_step();

    // Flush concurrent with issue records nothing.
    idle(); issue = 1; issue_wreg = 1; issue_wa = 7; issue_lat = 3; flush = 1;
    cycle();
    idle();
    settle();
    check_eq("fl_issue_r7", {63'd0, reg_busy[7]}, 64'd0);
    edge_step();

    // Asynchronous reset in the middle of a pending count.
    do_issue(10, 7, 0, 0);
    idle(); rreg1 = 1; ra1 = 10;
    settle();
    #2 rst_n = 0;
    m_clear();
    #1;
    check_eq("arst_busy", {32'd0, reg_busy}, 64'd0);
    check_eq("arst_stall", {63'd0, stallreq_id}, 64'd0);
    edge_step();
    rst_n = 1;
    settle();
    check_eq("arst_after_stall", {63'd0, stallreq_id}, 64'd0);
    edge_step();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      issue          = ($urandom_range(1, 0) == 1);
      issue_wreg     = ($urandom_range(3, 0) != 0);
      issue_wa       = AW'($urandom_range(7, 0));
      issue_lat      = LAT_W'($urandom_range(7, 0));
      issue_whilo    = ($urandom_range(4, 0) == 0);
      issue_hilo_lat = LAT_W'($urandom_range(7, 0));
      rreg1          = ($urandom_range(1, 0) == 1);
      rreg2          = ($urandom_range(1, 0) == 1);
      ra1            = AW'($urandom_range(7, 0));
      ra2            = AW'(($urandom_range(3, 0) == 0) ? $urandom_range(31, 0)
                                                      : $urandom_range(7, 0));
      rhilo          = ($urandom_range(3, 0) == 0);
      stall_ext      = ($urandom_range(6, 0) == 0);
      flush          = ($urandom_range(29, 0) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
